// File: rtl/alu_pkg.sv
// Shared ALU control encodings and arbiter FSM states.
package alu_pkg;

  localparam int unsigned DataWidth = 32;

  // ALUControl codes; 110 and 111 are reserved and yield result 0.
  typedef enum logic [2:0] {
    AluAdd  = 3'b000,
    AluSub  = 3'b001,
    AluAnd  = 3'b010,
    AluOr   = 3'b011,
    AluSlt  = 3'b100,
    AluXor  = 3'b101,
    AluRsv6 = 3'b110,
    AluRsv7 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU shared by both requesters of the arbiter.
module alu
  import alu_pkg::*;
(
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic [2:0]           op,
  output logic [DataWidth-1:0] result,
  output logic                 zero
);

  // Decode the operation; reserved codes fall through to zero.
  always_comb begin
    result = '0;
    case (op)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluSlt:  result = {{(DataWidth-1){1'b0}}, (a < b)};
      AluXor:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU.
// Each operation runs IDLE -> EXEC -> RESP; only one is in flight at a time.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [DataWidth-1:0] req0_a,
  input  logic [DataWidth-1:0] req0_b,
  input  logic [2:0]           req0_op,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DataWidth-1:0] req1_a,
  input  logic [DataWidth-1:0] req1_b,
  input  logic [2:0]           req1_op,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic [DataWidth-1:0] rsp0_result,
  output logic                 rsp0_zero,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  output logic [DataWidth-1:0] rsp1_result,
  output logic                 rsp1_zero,
  input  logic                 rsp1_ready
);

  localparam logic ResetPrioBit = (RESET_PRIO != 0);

  arb_state_e           state_q;
  logic                 prio_q;
  logic                 owner_q;
  logic [DataWidth-1:0] a_q;
  logic [DataWidth-1:0] b_q;
  logic [2:0]           op_q;
  logic [DataWidth-1:0] result_q;
  logic                 zero_q;

  logic                 gnt0;
  logic                 gnt1;
  logic                 accept;
  logic                 rsp_xfer;
  logic [DataWidth-1:0] alu_result;
  logic                 alu_zero;

  // Round-robin grant, only offered in IDLE and never while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && (state_q == StIdle)) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign rsp_xfer   = (state_q == StResp) && (owner_q ? rsp1_ready : rsp0_ready);

  // Outputs are forced quiet while reset is held, even before the reset edge.
  assign rsp0_valid  = !rst && (state_q == StResp) && !owner_q;
  assign rsp1_valid  = !rst && (state_q == StResp) && owner_q;
  assign rsp0_result = rst ? '0 : result_q;
  assign rsp1_result = rst ? '0 : result_q;
  assign rsp0_zero   = rst ? 1'b0 : zero_q;
  assign rsp1_zero   = rst ? 1'b0 : zero_q;

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Operation FSM: capture on accept, compute in EXEC, hold result in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      prio_q   <= ResetPrioBit;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q     <= gnt1 ? req1_a : req0_a;
            b_q     <= gnt1 ? req1_b : req0_b;
            op_q    <= gnt1 ? req1_op : req0_op;
            owner_q <= gnt1;
            // Priority passes to whoever was not just served.
            prio_q  <= gnt0;
            state_q <= StExec;
          end
        end
        StExec: begin
          result_q <= alu_result;
          zero_q   <= alu_zero;
          state_q  <= StResp;
        end
        StResp: begin
          if (rsp_xfer) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand-written corner
// sequences, and a randomized phase, all watched by a transaction-level model.
module tb_alu_share_arbiter;

  localparam int unsigned ResetPrio = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.RESET_PRIO(ResetPrio)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .req1_ready  (req1_ready),
    .rsp0_valid  (rsp0_valid),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp0_ready  (rsp0_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .rsp1_ready  (rsp1_ready)
  );

  always #5 clk = ~clk;

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference ALU straight from the operation table.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (a < b) ? 32'd1 : 32'd0;
      3'd5:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Transaction model: one operation outstanding at most, response visible two
  // edges after the accept cycle, priority alternates on every accept.
  bit          m_busy;
  int          m_age;
  bit          m_owner;
  bit          m_prio;
  logic [31:0] m_res;
  bit          m_eg0, m_eg1, m_ev0, m_ev1;

  always @(negedge clk) begin
    if (rst) begin
      check_bit("rst_req0_ready", req0_ready, 1'b0);
      check_bit("rst_req1_ready", req1_ready, 1'b0);
      check_bit("rst_rsp0_valid", rsp0_valid, 1'b0);
      check_bit("rst_rsp1_valid", rsp1_valid, 1'b0);
      check_word("rst_rsp0_result", rsp0_result, 32'h0);
      check_word("rst_rsp1_result", rsp1_result, 32'h0);
      check_bit("rst_rsp0_zero", rsp0_zero, 1'b0);
      check_bit("rst_rsp1_zero", rsp1_zero, 1'b0);
      m_busy = 1'b0;
      m_age  = 0;
      m_prio = (ResetPrio != 0);
    end else begin
      if (m_busy) m_age++;
      m_ev0 = m_busy && (m_age >= 2) && !m_owner;
      m_ev1 = m_busy && (m_age >= 2) && m_owner;
      check_bit("mdl_rsp0_valid", rsp0_valid, m_ev0);
      check_bit("mdl_rsp1_valid", rsp1_valid, m_ev1);
      if (m_ev0) begin
        check_word("mdl_rsp0_result", rsp0_result, m_res);
        check_bit("mdl_rsp0_zero", rsp0_zero, m_res == 32'h0);
      end
      if (m_ev1) begin
        check_word("mdl_rsp1_result", rsp1_result, m_res);
        check_bit("mdl_rsp1_zero", rsp1_zero, m_res == 32'h0);
      end
      m_eg0 = 1'b0;
      m_eg1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin
          m_eg0 = !m_prio;
          m_eg1 = m_prio;
        end else begin
          m_eg0 = req0_valid;
          m_eg1 = req1_valid;
        end
      end
      check_bit("mdl_req0_ready", req0_ready, m_eg0);
      check_bit("mdl_req1_ready", req1_ready, m_eg1);
      if ((m_ev0 && rsp0_ready) || (m_ev1 && rsp1_ready)) m_busy = 1'b0;
      if (m_eg0 || m_eg1) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_owner = m_eg1;
        m_prio  = m_eg0;
        m_res   = m_eg1 ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
      end
    end
  end

  task automatic drive_req(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic clr_req(input int n);
    if (n == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  // One operation with rsp_ready high: ready at once, response two edges later.
  task automatic run_vec(input int n, input vec_t v, input int idx);
    logic rdy, orr, rv, orv, z;
    logic [31:0] r;
    drive_req(n, v.a, v.b, v.op);
    @(negedge clk);
    rdy = (n == 0) ? req0_ready : req1_ready;
    orr = (n == 0) ? req1_ready : req0_ready;
    check_bit($sformatf("vec%0d_ready", idx), rdy, 1'b1);
    check_bit($sformatf("vec%0d_other_ready", idx), orr, 1'b0);
    next_cycle();
    clr_req(n);
    @(negedge clk);
    rv = (n == 0) ? rsp0_valid : rsp1_valid;
    check_bit($sformatf("vec%0d_exec_valid", idx), rv, 1'b0);
    next_cycle();
    @(negedge clk);
    rv  = (n == 0) ? rsp0_valid : rsp1_valid;
    orv = (n == 0) ? rsp1_valid : rsp0_valid;
    r   = (n == 0) ? rsp0_result : rsp1_result;
    z   = (n == 0) ? rsp0_zero : rsp1_zero;
    check_bit($sformatf("vec%0d_rsp_valid", idx), rv, 1'b1);
    check_bit($sformatf("vec%0d_other_valid", idx), orv, 1'b0);
    check_word($sformatf("vec%0d_result", idx), r, v.res);
    check_bit($sformatf("vec%0d_zero", idx), z, v.z);
    next_cycle();
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_rand(input int n);
    logic [31:0] a, b;
    a = rnd_word();
    b = ($urandom_range(0, 4) == 0) ? a : rnd_word();
    drive_req(n, a, b, 3'($urandom_range(0, 7)));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic a0, a1;
    vecs[0]  = '{a: 32'd5,         b: 32'd7,         op: 3'b000, res: 32'd12,        z: 1'b0};
    vecs[1]  = '{a: 32'd9,         b: 32'd9,         op: 3'b001, res: 32'd0,         z: 1'b1};
    vecs[2]  = '{a: 32'h0000_00F0, b: 32'h0000_0F00, op: 3'b011, res: 32'h0000_0FF0, z: 1'b0};
    vecs[3]  = '{a: 32'hF0F0_F0F0, b: 32'h0FF0_0FF0, op: 3'b010, res: 32'h00F0_00F0, z: 1'b0};
    vecs[4]  = '{a: 32'd3,         b: 32'hFFFF_FFFF, op: 3'b100, res: 32'd1,         z: 1'b0};
    vecs[5]  = '{a: 32'hFFFF_FFFF, b: 32'd3,         op: 3'b100, res: 32'd0,         z: 1'b1};
    vecs[6]  = '{a: 32'hAAAA_5555, b: 32'hFFFF_0000, op: 3'b101, res: 32'h5555_5555, z: 1'b0};
    vecs[7]  = '{a: 32'hFFFF_FFFF, b: 32'd1,         op: 3'b000, res: 32'd0,         z: 1'b1};
    vecs[8]  = '{a: 32'd0,         b: 32'd1,         op: 3'b001, res: 32'hFFFF_FFFF, z: 1'b0};
    vecs[9]  = '{a: 32'd1,         b: 32'd2,         op: 3'b110, res: 32'd0,         z: 1'b1};
    vecs[10] = '{a: 32'h1234_5678, b: 32'h9ABC_DEF0, op: 3'b111, res: 32'd0,         z: 1'b1};

    repeat (3) next_cycle();
    rst = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Directed table, alternating requesters.
    for (int i = 0; i < 11; i++) run_vec(i % 2, vecs[i], i);

    // Simultaneous requests from reset priority; req0 re-requests immediately.
    pulse_reset();
    drive_req(0, 32'd9, 32'd9, 3'b001);
    drive_req(1, 32'h0000_00F0, 32'h0000_0F00, 3'b011);
    @(negedge clk);
    check_bit("dual_req0_ready", req0_ready, 1'b1);
    check_bit("dual_req1_ready", req1_ready, 1'b0);
    next_cycle();
    drive_req(0, 32'd4, 32'd6, 3'b000);
    @(negedge clk);
    check_bit("dual_exec_req0_ready", req0_ready, 1'b0);
    check_bit("dual_exec_req1_ready", req1_ready, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("dual_rsp0_valid", rsp0_valid, 1'b1);
    check_word("dual_rsp0_result", rsp0_result, 32'h0);
    check_bit("dual_rsp0_zero", rsp0_zero, 1'b1);
    next_cycle();
    @(negedge clk);
    check_bit("repeat_req1_first", req1_ready, 1'b1);
    check_bit("repeat_req0_wait", req0_ready, 1'b0);
    next_cycle();
    clr_req(1);
    next_cycle();
    @(negedge clk);
    check_bit("dual_rsp1_valid", rsp1_valid, 1'b1);
    check_word("dual_rsp1_result", rsp1_result, 32'h0000_0FF0);
    check_bit("dual_rsp1_zero", rsp1_zero, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("repeat_req0_ready", req0_ready, 1'b1);
    next_cycle();
    clr_req(0);
    next_cycle();
    @(negedge clk);
    check_word("repeat_rsp0_result", rsp0_result, 32'd10);
    next_cycle();

    // Backpressure on rsp1 while req0 waits.
    rsp1_ready = 1'b0;
    drive_req(1, 32'd3, 32'hFFFF_FFFF, 3'b100);
    @(negedge clk);
    check_bit("bp_req1_ready", req1_ready, 1'b1);
    next_cycle();
    clr_req(1);
    drive_req(0, 32'd11, 32'd22, 3'b000);
    @(negedge clk);
    check_bit("bp_exec_req0_ready", req0_ready, 1'b0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit($sformatf("bp_hold%0d_valid", i), rsp1_valid, 1'b1);
      check_word($sformatf("bp_hold%0d_result", i), rsp1_result, 32'd1);
      check_bit($sformatf("bp_hold%0d_req0_ready", i), req0_ready, 1'b0);
      next_cycle();
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_xfer_valid", rsp1_valid, 1'b1);
    check_bit("bp_xfer_req0_ready", req0_ready, 1'b0);
    next_cycle();
    @(negedge clk);
    check_bit("bp_after_req0_ready", req0_ready, 1'b1);
    next_cycle();
    clr_req(0);
    next_cycle();
    @(negedge clk);
    check_word("bp_rsp0_result", rsp0_result, 32'd33);
    next_cycle();

    // Reset pulsed in EXEC drops the operation and restores priority.
    drive_req(0, 32'd1, 32'd1, 3'b000);
    @(negedge clk);
    check_bit("rmid_req0_ready", req0_ready, 1'b1);
    next_cycle();
    clr_req(0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit($sformatf("rmid_rsp0_quiet%0d", i), rsp0_valid, 1'b0);
      check_bit($sformatf("rmid_rsp1_quiet%0d", i), rsp1_valid, 1'b0);
      next_cycle();
    end
    drive_req(0, 32'd2, 32'd3, 3'b000);
    drive_req(1, 32'd8, 32'd4, 3'b001);
    @(negedge clk);
    check_bit("rmid_prio_req0", req0_ready, 1'b1);
    check_bit("rmid_prio_req1", req1_ready, 1'b0);
    next_cycle();
    clr_req(0);
    next_cycle();
    @(negedge clk);
    check_word("rmid_rsp0_result", rsp0_result, 32'd5);
    next_cycle();
    @(negedge clk);
    check_bit("rmid_req1_ready", req1_ready, 1'b1);
    next_cycle();
    clr_req(1);
    next_cycle();
    @(negedge clk);
    check_word("rmid_rsp1_result", rsp1_result, 32'd4);
    next_cycle();

    // Randomized traffic against the transaction model.
    a0 = 1'b0;
    a1 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (a0) clr_req(0);
      if (a1) clr_req(1);
      rst = ($urandom_range(0, 199) == 0);
      if (!req0_valid && ($urandom_range(0, 2) == 0)) drive_rand(0);
      if (!req1_valid && ($urandom_range(0, 2) == 0)) drive_rand(1);
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      next_cycle();
    end
    rst = 1'b0;
    clr_req(0);
    clr_req(1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
